// File: rtl/mips_debug_pkg.sv
// Shared constants for the MIPS debug controller: UART byte codes,
// controller state encoding and default widths.
package mips_debug_pkg;

  localparam int NB_DATA = 8;
  localparam int LEN     = 32;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_CLEAR = 8'h52;

  localparam logic [7:0] RSP_ACK_LOAD = 8'hAA;
  localparam logic [7:0] RSP_ACK_STEP = 8'h5A;
  localparam logic [7:0] RSP_HALTED   = 8'hDD;
  localparam logic [7:0] RSP_ERR      = 8'hEE;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD_CNT  = 3'd1;
  localparam state_t ST_LOAD_WORD = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_STEP      = 3'd4;
  localparam state_t ST_TX        = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  // A load count must name at least one word and fit in program memory.
  function automatic logic count_valid(input logic [7:0] n, input logic [7:0] depth);
    return (n != 8'd0) && (n <= depth);
  endfunction

endpackage

// File: rtl/debug_word_assembler.sv
// Packs UART bytes MSB-first into program words and pulses word_valid
// for one cycle after the last byte of each word.
module debug_word_assembler #(
  parameter int NB_DATA = 8,
  parameter int LEN     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [NB_DATA-1:0] data,
  output logic [LEN-1:0]     word,
  output logic               word_valid
);

  localparam int         NB_SHIFT  = LEN - NB_DATA;
  localparam logic [1:0] LAST_BYTE = 2'(LEN / NB_DATA - 1);

  logic [NB_SHIFT-1:0] shift;
  logic [1:0]          count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      count      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shift <= '0;
        count <= '0;
      end else if (push) begin
        if (count == LAST_BYTE) begin
          word       <= {shift, data};
          word_valid <= 1'b1;
          shift      <= '0;
          count      <= '0;
        end else begin
          shift <= {shift[NB_SHIFT-NB_DATA-1:0], data};
          count <= count + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Debug/sequencing controller for the pipelined MIPS core: command decode, program
// load, run/step gating and status reporting. Optional macro: MIPS_DEBUG_CYCLE_REPORT_EN.
module mips_debug_ctrl #(
  parameter int NB_DATA           = mips_debug_pkg::NB_DATA,
  parameter int LEN               = mips_debug_pkg::LEN,
  parameter int RAM_DEPTH_PROGRAM = 32,
  parameter int NB_PC_ADDR        = $clog2(RAM_DEPTH_PROGRAM),
  parameter int NB_CYCLES         = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_prog_we,
  output logic [NB_PC_ADDR-1:0] o_prog_addr,
  output logic [LEN-1:0]        o_prog_data,
  output logic                  o_cpu_en,
  output logic                  o_cpu_clr,
  input  logic                  i_halt,
  output logic [NB_CYCLES-1:0]  o_cycles
);

  import mips_debug_pkg::*;

  localparam logic [NB_DATA-1:0] DEPTH_B = NB_DATA'(RAM_DEPTH_PROGRAM);

  state_t                state;
  state_t                ret_state;
  logic [NB_DATA-1:0]    tx_data;
  logic                  tx_valid;
  logic                  cpu_en;
  logic                  cpu_clr;
  logic [NB_CYCLES-1:0]  cycles;
  logic [NB_PC_ADDR-1:0] index;
  logic [NB_PC_ADDR-1:0] last_idx;
  logic                  word_valid;
`ifdef MIPS_DEBUG_CYCLE_REPORT_EN
  logic [2:0]            rep_left;
`endif

  debug_word_assembler #(
    .NB_DATA (NB_DATA),
    .LEN     (LEN)
  ) u_word_asm (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .clear      (state != ST_LOAD_WORD),
    .push       (i_rx_valid && (state == ST_LOAD_WORD)),
    .data       (i_rx_data),
    .word       (o_prog_data),
    .word_valid (word_valid)
  );

  assign o_prog_we   = word_valid;
  assign o_prog_addr = index;
  assign o_tx_data   = tx_data;
  assign o_tx_valid  = tx_valid;
  assign o_cpu_en    = cpu_en;
  assign o_cpu_clr   = cpu_clr;
  assign o_cycles    = cycles;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      cpu_en    <= 1'b0;
      cpu_clr   <= 1'b0;
      cycles    <= '0;
      index     <= '0;
      last_idx  <= '0;
`ifdef MIPS_DEBUG_CYCLE_REPORT_EN
      rep_left  <= '0;
`endif
    end else begin
      cpu_clr <= 1'b0;
      if (cpu_en && (cycles != '1))
        cycles <= cycles + NB_CYCLES'(1);

      case (state)
        // DONE shares the IDLE decoder but only honours load and clear.
        ST_IDLE, ST_DONE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              state <= ST_LOAD_CNT;
            end else if (i_rx_data == CMD_CLEAR) begin
              cpu_clr <= 1'b1;
              cycles  <= '0;
              state   <= ST_IDLE;
            end else if ((state == ST_IDLE) && (i_rx_data == CMD_CONT)) begin
              cpu_en <= 1'b1;
              state  <= ST_RUN;
            end else if ((state == ST_IDLE) && (i_rx_data == CMD_STEP)) begin
              cpu_en <= 1'b1;
              state  <= ST_STEP;
            end
          end
        end

        ST_LOAD_CNT: begin
          if (i_rx_valid) begin
            if (!count_valid(i_rx_data, DEPTH_B)) begin
              tx_data   <= RSP_ERR;
              tx_valid  <= 1'b1;
              ret_state <= ST_IDLE;
              state     <= ST_TX;
            end else begin
              index    <= '0;
              last_idx <= NB_PC_ADDR'(i_rx_data - NB_DATA'(1));
              state    <= ST_LOAD_WORD;
            end
          end
        end

        // The write strobe comes straight from the assembler; here we only
        // advance the address once that write cycle has been seen.
        ST_LOAD_WORD: begin
          if (word_valid) begin
            if (index == last_idx) begin
              cpu_clr   <= 1'b1;
              cycles    <= '0;
              tx_data   <= RSP_ACK_LOAD;
              tx_valid  <= 1'b1;
              ret_state <= ST_IDLE;
              state     <= ST_TX;
            end else begin
              index <= index + NB_PC_ADDR'(1);
            end
          end
        end

        ST_RUN: begin
          if (i_halt) begin
            cpu_en    <= 1'b0;
            tx_data   <= RSP_HALTED;
            tx_valid  <= 1'b1;
            ret_state <= ST_DONE;
            state     <= ST_TX;
`ifdef MIPS_DEBUG_CYCLE_REPORT_EN
            rep_left  <= 3'd4;
`endif
          end
        end

        ST_STEP: begin
          cpu_en <= 1'b0;
          tx_valid <= 1'b1;
          state    <= ST_TX;
          if (i_halt) begin
            tx_data   <= RSP_HALTED;
            ret_state <= ST_DONE;
`ifdef MIPS_DEBUG_CYCLE_REPORT_EN
            rep_left  <= 3'd4;
`endif
          end else begin
            tx_data   <= RSP_ACK_STEP;
            ret_state <= ST_IDLE;
          end
        end

        // Each byte gets its own handshake followed by one idle cycle.
        ST_TX: begin
          if (tx_valid) begin
            if (i_tx_ready) begin
              tx_valid <= 1'b0;
`ifdef MIPS_DEBUG_CYCLE_REPORT_EN
              if (rep_left == '0)
                state <= ret_state;
`else
              state <= ret_state;
`endif
            end
          end else begin
`ifdef MIPS_DEBUG_CYCLE_REPORT_EN
            tx_valid <= 1'b1;
            tx_data  <= NB_DATA'(cycles >> {2'(rep_left - 3'd1), 3'b000});
            rep_left <= rep_left - 3'd1;
`else
            state <= ret_state;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: table-driven loads, hand-written
// corner sequences and randomized operations against a behavioural model.
module tb_mips_debug_ctrl;

  localparam int LIMIT = 400;
  localparam logic [7:0] C_L = 8'h4C, C_C = 8'h43, C_S = 8'h53, C_R = 8'h52;
  localparam logic [7:0] A_LOAD = 8'hAA, A_STEP = 8'h5A, HALTED = 8'hDD, ERR = 8'hEE;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] n;
    logic [7:0] resp;
    int         writes;
  } load_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;
  logic        cpu_en;
  logic        cpu_clr;
  logic        halt = 1'b0;
  logic [31:0] cycles;

  int  checks = 0;
  int  errors = 0;
  int  en_cnt = 0;
  int  clr_cnt = 0;
  bit  rand_ready = 1'b0;
  wr_t wq[$];
  logic [7:0] txq[$];

  longint m_cycles = 0;
  bit     m_done = 1'b0;

  mips_debug_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_prog_we   (prog_we),
    .o_prog_addr (prog_addr),
    .o_prog_data (prog_data),
    .o_cpu_en    (cpu_en),
    .o_cpu_clr   (cpu_clr),
    .i_halt      (halt),
    .o_cycles    (cycles)
  );

  always #5 clk = ~clk;

  // Observe handshakes and strobes mid-cycle, away from the active edge.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (rst_n) begin
      if (prog_we) begin
        w.addr = prog_addr;
        w.data = prog_data;
        wq.push_back(w);
      end
      if (cpu_clr) clr_cnt++;
      if (cpu_en) en_cnt++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic longint satAdd(input longint a, input longint k);
    return (a + k > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : a + k;
  endfunction

  task automatic waitTx(input logic [7:0] exp, input string name);
    int n = 0;
    while (txq.size() == 0 && n < LIMIT) begin
      tick();
      n++;
    end
    if (txq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout actual=none expected=0x%0h", name, exp);
    end else begin
      checkOutput(name, txq.pop_front(), exp);
    end
  endtask

  task automatic reportTail();
`ifdef MIPS_DEBUG_CYCLE_REPORT_EN
    logic [31:0] mc;
    mc = m_cycles[31:0];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = mc[31-8*i -: 8];
      waitTx(b, "cycle_report");
    end
`endif
  endtask

  task automatic checkState();
    checkOutput("cycles", cycles, m_cycles);
    checkOutput("cpu_en_idle", cpu_en, 1'b0);
    checkOutput("tx_extra", txq.size(), 0);
  endtask

  task automatic doLoad(input logic [7:0] n, input logic [7:0] exp_resp, input int exp_writes,
                        input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] words [32];
    logic [31:0] w;
    int c0;
    c0 = clr_cnt;
    wq.delete();
    applyStimulus(C_L);
    idle($urandom_range(0, 2));
    applyStimulus(n);
    for (int i = 0; i < exp_writes; i++) begin
      words[i] = (i == 0) ? w0 : (i == 1) ? w1 : $urandom();
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, 2));
        applyStimulus(w[31-8*b -: 8]);
      end
    end
    waitTx(exp_resp, "load_resp");
    idle(2);
    checkOutput("load_writes", wq.size(), exp_writes);
    for (int i = 0; i < exp_writes && i < wq.size(); i++) begin
      checkOutput("wr_addr", wq[i].addr, i);
      checkOutput("wr_data", wq[i].data, words[i]);
    end
    checkOutput("load_clr", clr_cnt - c0, (exp_writes > 0) ? 1 : 0);
    if (exp_writes > 0) m_cycles = 0;
    m_done = 1'b0;
    checkState();
  endtask

  task automatic doRun(input int k, input bit noise);
    int e0, c0;
    e0 = en_cnt;
    c0 = clr_cnt;
    applyStimulus(C_C);
    if (m_done) begin
      idle(4);
      checkOutput("done_run_en", en_cnt - e0, 0);
    end else begin
      for (int j = 1; j < k; j++) begin
        if (noise && $urandom_range(0, 3) == 0) applyStimulus(8'($urandom()));
        else tick();
      end
      halt = 1'b1;
      m_cycles = satAdd(m_cycles, k);
      m_done = 1'b1;
      waitTx(HALTED, "run_halted");
      reportTail();
      halt = 1'b0;
      idle(2);
      checkOutput("run_en_cycles", en_cnt - e0, k);
      checkOutput("run_no_clr", clr_cnt - c0, 0);
    end
    checkState();
  endtask

  task automatic doStep(input bit h, input bit stall);
    int e0, n;
    logic [7:0] exp;
    e0 = en_cnt;
    exp = h ? HALTED : A_STEP;
    if (stall) begin
      rand_ready = 1'b0;
      tx_ready = 1'b0;
    end
    applyStimulus(C_S);
    if (!m_done) halt = h;
    tick();
    halt = 1'b0;
    if (m_done) begin
      idle(4);
      checkOutput("done_step_en", en_cnt - e0, 0);
    end else begin
      if (stall) begin
        n = 0;
        while (!tx_valid && n < LIMIT) begin
          tick();
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          if (i == 2) applyStimulus(C_C);
          else tick();
          checkOutput("stall_valid", tx_valid, 1'b1);
          checkOutput("stall_data", tx_data, exp);
        end
        tx_ready = 1'b1;
      end
      m_cycles = satAdd(m_cycles, 1);
      m_done = h;
      waitTx(exp, "step_resp");
      if (h) reportTail();
      idle(2);
      checkOutput("step_en_cycles", en_cnt - e0, 1);
    end
    checkState();
  endtask

  task automatic doClear();
    int c0;
    c0 = clr_cnt;
    applyStimulus(C_R);
    idle(2);
    checkOutput("clear_pulse", clr_cnt - c0, 1);
    m_cycles = 0;
    m_done = 1'b0;
    checkState();
  endtask

  task automatic doGarbage(input logic [7:0] b);
    int e0, c0;
    e0 = en_cnt;
    c0 = clr_cnt;
    applyStimulus(b);
    idle(3);
    checkOutput("garbage_en", en_cnt - e0, 0);
    checkOutput("garbage_clr", clr_cnt - c0, 0);
    checkState();
  endtask

  function automatic logic [7:0] garbageByte();
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom());
      if (b != C_L && b != C_C && b != C_S && b != C_R) break;
      b = 8'h00;
    end
    return b;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
    checkOutput({tag, "_tx_valid"}, tx_valid, 1'b0);
    checkOutput({tag, "_prog_we"}, prog_we, 1'b0);
    checkOutput({tag, "_prog_addr"}, prog_addr, 5'd0);
    checkOutput({tag, "_prog_data"}, prog_data, 32'd0);
    checkOutput({tag, "_cpu_en"}, cpu_en, 1'b0);
    checkOutput({tag, "_cpu_clr"}, cpu_clr, 1'b0);
    checkOutput({tag, "_cycles"}, cycles, 32'd0);
  endtask

  initial begin
    load_vec_t lv [6];
    logic [7:0] n;
    logic [31:0] w;

    lv[0] = '{n: 8'h02, resp: A_LOAD, writes: 2};
    lv[1] = '{n: 8'h00, resp: ERR,    writes: 0};
    lv[2] = '{n: 8'h21, resp: ERR,    writes: 0};
    lv[3] = '{n: 8'h01, resp: A_LOAD, writes: 1};
    lv[4] = '{n: 8'h20, resp: A_LOAD, writes: 32};
    lv[5] = '{n: 8'hFF, resp: ERR,    writes: 0};

    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      doLoad(lv[i].n, lv[i].resp, lv[i].writes,
             (i == 0) ? 32'h2001_0005 : $urandom(), (i == 0) ? 32'h0000_003F : $urandom());

    doClear();
    doStep(1'b0, 1'b0);
    doStep(1'b0, 1'b1);
    doStep(1'b0, 1'b0);
    checkOutput("three_steps", cycles, 32'd3);

    doClear();
    doRun(11, 1'b0);
    checkOutput("run_11", cycles, 32'd11);

    doRun(5, 1'b0);
    doStep(1'b0, 1'b0);
    doGarbage(garbageByte());
    doClear();
    doStep(1'b0, 1'b0);
    doStep(1'b1, 1'b0);

    wq.delete();
    applyStimulus(C_L);
    applyStimulus(8'h02);
    w = 32'hCAFE_0001;
    for (int b = 0; b < 4; b++) applyStimulus(w[31-8*b -: 8]);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    checkOutput("prerst_writes", wq.size(), 1);
    if (wq.size() > 0) checkOutput("prerst_data", wq[0].data, 32'hCAFE_0001);
    @(negedge clk);
    rst_n = 1'b1;
    m_cycles = 0;
    m_done = 1'b0;
    tick();
    doLoad(8'h02, A_LOAD, 2, 32'h1122_3344, 32'h5566_7788);

    rand_ready = 1'b1;
    for (int op = 0; op < 80; op++) begin
      case ($urandom_range(0, 5))
        0: begin
          case ($urandom_range(0, 9))
            0:       n = 8'h00;
            1:       n = 8'($urandom_range(33, 255));
            default: n = 8'($urandom_range(1, 6));
          endcase
          if (n != 0 && n <= 32) doLoad(n, A_LOAD, int'(n), $urandom(), $urandom());
          else doLoad(n, ERR, 0, $urandom(), $urandom());
        end
        1:       doRun($urandom_range(1, 20), 1'b1);
        2, 3:    doStep($urandom_range(0, 3) == 0, 1'b0);
        4:       doClear();
        default: doGarbage(garbageByte());
      endcase
    end
    rand_ready = 1'b0;
    tx_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
